// File: rtl/bin2x2_avg_filter_if.sv
// Pixel stream bundle for the 2x2 binning stage: upstream pixel input side
// plus the registered binned output side.
interface bin2x2_avg_filter_if #(
  parameter int PIXEL_BIT_WIDTH = 12
) ();
  logic [PIXEL_BIT_WIDTH-1:0] pixel_in;
  logic                       in_valid;
  logic                       in_ready;
  logic [PIXEL_BIT_WIDTH-1:0] pixel_out;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;

  // Drives pixels in and consumes binned pixels.
  modport master (
    output pixel_in, in_valid, out_ready,
    input  in_ready, pixel_out, out_valid, out_last
  );

  // The binning stage itself.
  modport slave (
    input  pixel_in, in_valid, out_ready,
    output in_ready, pixel_out, out_valid, out_last
  );
endinterface

// File: rtl/bin2x2_avg_filter.sv
// Streaming 2x2 non-overlapping block average: half-width line buffer of
// pair sums from even rows, completed on odd rows into one registered output.
module bin2x2_avg_filter #(
  parameter int PIXEL_BIT_WIDTH = 12,
  parameter int IN_ROWS         = 20,
  parameter int IN_COLS         = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  bin2x2_avg_filter_if.slave   bus
);
  localparam int PW  = PIXEL_BIT_WIDTH;
  localparam int XW  = $clog2(IN_COLS);
  localparam int YW  = $clog2(IN_ROWS);
  localparam int LBN = IN_COLS / 2;
  localparam int LBW = (LBN > 1) ? $clog2(LBN) : 1;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [PW-1:0] h_q, h_d;
  logic [PW-1:0] pixel_out_q, pixel_out_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [PW:0]   lb_q [LBN];

  logic          accept;
  logic          x_last, y_last;
  logic          gen;
  logic [LBW-1:0] lb_idx;
  logic [PW+1:0] sum;

  // Single output register: a drained slot can be refilled in the same cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign x_last       = (x_q == XW'(IN_COLS - 1));
  assign y_last       = (y_q == YW'(IN_ROWS - 1));
  assign gen          = accept && y_q[0] && x_q[0];
  assign lb_idx       = LBW'(x_q >> 1);
  assign sum          = (PW+2)'(lb_q[lb_idx]) + (PW+2)'(h_q) + (PW+2)'(bus.pixel_in);

  always_comb begin
    // NOTE: every next-state value gets its hold default first so no path
    // through the branches below can leave one unassigned and infer a latch.
    x_d         = x_q;
    y_d         = y_q;
    h_d         = h_q;
    pixel_out_d = pixel_out_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    if (accept) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      if (!x_q[0]) h_d = bus.pixel_in;
    end

    if (gen) begin
      pixel_out_d = PW'(sum >> 2);
      out_valid_d = 1'b1;
      out_last_d  = y_last && x_last;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      h_q         <= '0;
      pixel_out_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      h_q         <= h_d;
      pixel_out_q <= pixel_out_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: the line buffer is deliberately not reset: each entry is written on
  // an even row before its odd-row read, so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (accept && !y_q[0] && x_q[0]) begin
      lb_q[lb_idx] <= (PW+1)'(h_q) + (PW+1)'(bus.pixel_in);
    end
  end

  assign bus.pixel_out = pixel_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
endmodule
